// File: rtl/baseline_sched.sv
// ----------------------------------------------------------------------------
// baseline_sched
//
// Timing controller for the multi-rate line-length baseline pipeline.
// Counts input sample beats and issues one-cycle load strobes to the four
// cascaded window shift registers (0.2 s segment, 1 s, 5 s and 30 s sums).
// Tracks per-stage fill status, runs the IDLE/FILL/RUN sequence and flags
// each update of the 240 s baseline output.
//
// Parameters
//   SEG_LEN   samples per segment                       (>= 2)
//   D1..D4    depth of each cascaded window stage       (>= 2)
//   CNT_W     width of win_count
//
// Ports
//   clk         in   1      clock
//   rst         in   1      synchronous reset, active low
//   en          in   1      active low; 1 freezes counters, FSM and new strobes
//   restart     in   1      1-cycle pulse: clear counts and fill, back to IDLE
//   sample_vld  in   1      one pulse per new input sample
//   ld_s1..4    out  1      registered one-cycle load strobes, stage 1..4
//   full        out  4      full[k-1]: stage k has taken >= Dk loads
//   state       out  2      00 IDLE, 01 FILL, 10 RUN
//   out_vld     out  1      1-cycle pulse: 240 s baseline updated and valid
//   win_count   out  CNT_W  saturating count of out_vld pulses
//
// Handshake: sample_vld is a fire-and-forget pulse with no back-pressure.
// A sample is taken on any cycle where sample_vld=1, en=0 and restart=0;
// back-to-back pulses are each taken, one per cycle.
// ----------------------------------------------------------------------------
module baseline_sched #(
    parameter int SEG_LEN = 50,
    parameter int D1      = 5,
    parameter int D2      = 5,
    parameter int D3      = 6,
    parameter int D4      = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             sample_vld,
    output logic             ld_s1,
    output logic             ld_s2,
    output logic             ld_s3,
    output logic             ld_s4,
    output logic [3:0]       full,
    output logic [1:0]       state,
    output logic             out_vld,
    output logic [CNT_W-1:0] win_count
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    // Beat counter widths
    localparam int W0 = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam int W1 = (D1 > 1) ? $clog2(D1) : 1;
    localparam int W2 = (D2 > 1) ? $clog2(D2) : 1;
    localparam int W3 = (D3 > 1) ? $clog2(D3) : 1;

    // Load counter widths: must hold the saturation value Dk itself
    localparam int L1 = $clog2(D1 + 1);
    localparam int L2 = $clog2(D2 + 1);
    localparam int L3 = $clog2(D3 + 1);
    localparam int L4 = $clog2(D4 + 1);

    localparam logic [W0-1:0] C0_MAX = W0'(SEG_LEN - 1);
    localparam logic [W1-1:0] C1_MAX = W1'(D1 - 1);
    localparam logic [W2-1:0] C2_MAX = W2'(D2 - 1);
    localparam logic [W3-1:0] C3_MAX = W3'(D3 - 1);

    localparam logic [L1-1:0] F1     = L1'(D1);
    localparam logic [L2-1:0] F2     = L2'(D2);
    localparam logic [L3-1:0] F3     = L3'(D3);
    localparam logic [L4-1:0] F4     = L4'(D4);
    localparam logic [L4-1:0] F4_M1  = L4'(D4 - 1);

    localparam logic [CNT_W-1:0] WIN_MAX = {CNT_W{1'b1}};

    // State registers
    logic [W0-1:0]    c0_q, c0_d;
    logic [W1-1:0]    c1_q, c1_d;
    logic [W2-1:0]    c2_q, c2_d;
    logic [W3-1:0]    c3_q, c3_d;
    logic [L1-1:0]    lc1_q, lc1_d;
    logic [L2-1:0]    lc2_q, lc2_d;
    logic [L3-1:0]    lc3_q, lc3_d;
    logic [L4-1:0]    lc4_q, lc4_d;
    logic             ld1_q, ld1_d;
    logic             ld2_q, ld2_d;
    logic             ld3_q, ld3_d;
    logic             ld4_q, ld4_d;
    logic [1:0]       state_q, state_d;
    logic             out_vld_q, out_vld_d;
    logic [CNT_W-1:0] win_q, win_d;

    // Decode
    logic acc;
    logic w0, w1, w2, w3;
    logic full1, full2, full3, full4;
    logic full4_set;

    // Fill flags are decoded straight from the load counters. Because a load
    // counter advances on the same edge that registers its strobe, full[k-1]
    // rises in the same cycle as the Dk-th ld_sk.
    assign full1 = (lc1_q == F1);
    assign full2 = (lc2_q == F2);
    assign full3 = (lc3_q == F3);
    assign full4 = (lc4_q == F4);

    always_comb begin
        // restart wins over a coincident sample: that sample is dropped
        acc = sample_vld & ~en & ~restart;

        // Wrap chain: each stage wraps only when every stage below it wraps
        w0 = acc && (c0_q == C0_MAX);
        w1 = w0  && (c1_q == C1_MAX);
        w2 = w1  && (c2_q == C2_MAX);
        w3 = w2  && (c3_q == C3_MAX);

        // This accepted sample produces the D4-th stage-4 load
        full4_set = w3 && (lc4_q == F4_M1);

        c0_d  = c0_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        c3_d  = c3_q;
        lc1_d = lc1_q;
        lc2_d = lc2_q;
        lc3_d = lc3_q;
        lc4_d = lc4_q;

        if (restart) begin
            c0_d  = '0;
            c1_d  = '0;
            c2_d  = '0;
            c3_d  = '0;
            lc1_d = '0;
            lc2_d = '0;
            lc3_d = '0;
            lc4_d = '0;
        end else begin
            if (acc) c0_d = w0 ? '0 : c0_q + W0'(1);
            if (w0)  c1_d = w1 ? '0 : c1_q + W1'(1);
            if (w1)  c2_d = w2 ? '0 : c2_q + W2'(1);
            if (w2)  c3_d = w3 ? '0 : c3_q + W3'(1);

            if (w0 && !full1) lc1_d = lc1_q + L1'(1);
            if (w1 && !full2) lc2_d = lc2_q + L2'(1);
            if (w2 && !full3) lc3_d = lc3_q + L3'(1);
            if (w3 && !full4) lc4_d = lc4_q + L4'(1);
        end

        // Strobes are plain registered wraps; acc already folds in en and
        // restart, so a freeze or restart simply lets a pending strobe drop.
        ld1_d = w0;
        ld2_d = w1;
        ld3_d = w2;
        ld4_d = w3;

        state_d = state_q;
        if (restart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (acc)       state_d = full4_set ? ST_RUN : ST_FILL;
                ST_FILL: if (full4_set) state_d = ST_RUN;
                ST_RUN:                 state_d = ST_RUN;
                default:                state_d = ST_IDLE;
            endcase
        end

        // One cycle after each stage-4 load that lands with the stage full.
        // Suppressed while frozen so the pulse count and win_count agree.
        out_vld_d = ld4_q & full4 & ~en & ~restart;

        win_d = win_q;
        if (restart) begin
            win_d = '0;
        end else if (out_vld_d && (win_q != WIN_MAX)) begin
            win_d = win_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c0_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            c3_q      <= '0;
            lc1_q     <= '0;
            lc2_q     <= '0;
            lc3_q     <= '0;
            lc4_q     <= '0;
            ld1_q     <= 1'b0;
            ld2_q     <= 1'b0;
            ld3_q     <= 1'b0;
            ld4_q     <= 1'b0;
            state_q   <= ST_IDLE;
            out_vld_q <= 1'b0;
            win_q     <= '0;
        end else begin
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            c3_q      <= c3_d;
            lc1_q     <= lc1_d;
            lc2_q     <= lc2_d;
            lc3_q     <= lc3_d;
            lc4_q     <= lc4_d;
            ld1_q     <= ld1_d;
            ld2_q     <= ld2_d;
            ld3_q     <= ld3_d;
            ld4_q     <= ld4_d;
            state_q   <= state_d;
            out_vld_q <= out_vld_d;
            win_q     <= win_d;
        end
    end

    assign ld_s1     = ld1_q;
    assign ld_s2     = ld2_q;
    assign ld_s3     = ld3_q;
    assign ld_s4     = ld4_q;
    assign full      = {full4, full3, full2, full1};
    assign state     = state_q;
    assign out_vld   = out_vld_q;
    assign win_count = win_q;

endmodule

// File: tb/tb_baseline_sched.sv
// ----------------------------------------------------------------------------
// tb_baseline_sched
//
// Directed bench for baseline_sched. Instance a_dut uses a shrunken
// configuration (SEG_LEN=2, all depths 2) so every strobe boundary is cheap to
// reach; instance b_dut uses the default configuration for the long-run and
// mid-window reset checks. Inputs change on the falling edge; outputs are
// read on the following falling edge, i.e. after the rising edge between.
// ----------------------------------------------------------------------------
module tb_baseline_sched;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (small parameters)
    logic        a_rst, a_en, a_restart, a_vld;
    logic        a_ld1, a_ld2, a_ld3, a_ld4;
    logic [3:0]  a_full;
    logic [1:0]  a_state;
    logic        a_out_vld;
    logic [15:0] a_win;

    // Instance B (default parameters)
    logic        b_rst, b_en, b_restart, b_vld;
    logic        b_ld1, b_ld2, b_ld3, b_ld4;
    logic [3:0]  b_full;
    logic [1:0]  b_state;
    logic        b_out_vld;
    logic [15:0] b_win;

    baseline_sched #(
        .SEG_LEN(2), .D1(2), .D2(2), .D3(2), .D4(2), .CNT_W(16)
    ) a_dut (
        .clk(clk), .rst(a_rst), .en(a_en), .restart(a_restart),
        .sample_vld(a_vld),
        .ld_s1(a_ld1), .ld_s2(a_ld2), .ld_s3(a_ld3), .ld_s4(a_ld4),
        .full(a_full), .state(a_state), .out_vld(a_out_vld),
        .win_count(a_win)
    );

    baseline_sched b_dut (
        .clk(clk), .rst(b_rst), .en(b_en), .restart(b_restart),
        .sample_vld(b_vld),
        .ld_s1(b_ld1), .ld_s2(b_ld2), .ld_s3(b_ld3), .ld_s4(b_ld4),
        .full(b_full), .state(b_state), .out_vld(b_out_vld),
        .win_count(b_win)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle on A: called at a falling edge, returns at the next one.
    task automatic a_cycle(input logic vld, input logic e, input logic rs,
                           input logic rst_n);
        a_vld     = vld;
        a_en      = e;
        a_restart = rs;
        a_rst     = rst_n;
        @(negedge clk);
    endtask

    task automatic a_samples(input int n);
        for (int i = 0; i < n; i++) a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic b_cycle(input logic vld, input logic rst_n);
        b_vld = vld;
        b_rst = rst_n;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen;
        int   n1, n4, nov, first1, first4, ov_at;

        a_rst = 1'b0; a_en = 1'b0; a_restart = 1'b0; a_vld = 1'b0;
        b_rst = 1'b0; b_en = 1'b0; b_restart = 1'b0; b_vld = 1'b0;
        @(negedge clk);

        // Reset state
        a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state",  32'(a_state), 32'd0);
        check("rst_full",   32'(a_full),  32'd0);
        check("rst_win",    32'(a_win),   32'd0);
        check("rst_strobe", 32'({a_out_vld, a_ld4, a_ld3, a_ld2, a_ld1}), 32'd0);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_hold",  32'(a_state), 32'd0);

        // Four back-to-back samples: ld_s1 after samples 2 and 4
        exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
        for (int i = 1; i <= 4; i++) begin
            a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
            check($sformatf("t1_ld_s1_%0d", i), 32'(a_ld1), exp_q.pop_front());
            if (i == 1) check("t1_state_fill", 32'(a_state), 32'd1);
            if (i == 2) check("t1_ld_s2_low",  32'(a_ld2),   32'd0);
            if (i == 4) begin
                check("t1_ld_s2", 32'(a_ld2), 32'd1);
                check("t1_ld_s3", 32'(a_ld3), 32'd0);
            end
        end

        // Sample 16: all four strobes together, then full=0111
        a_samples(11);
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_ld_all", 32'({a_ld4, a_ld3, a_ld2, a_ld1}), 32'hf);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_ld_clear", 32'({a_ld4, a_ld3, a_ld2, a_ld1}), 32'h0);
        check("t2_full",     32'(a_full),  32'h7);
        check("t2_state",    32'(a_state), 32'd1);

        // Sample 32: full[3] and RUN together, out_vld one cycle later
        a_samples(15);
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_ld_s4",     32'(a_ld4),     32'd1);
        check("t3_full",      32'(a_full),    32'hf);
        check("t3_state_run", 32'(a_state),   32'd2);
        check("t3_ovld_early",32'(a_out_vld), 32'd0);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_out_vld",   32'(a_out_vld), 32'd1);
        check("t3_win",       32'(a_win),     32'd1);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_ovld_pulse",32'(a_out_vld), 32'd0);
        check("t3_win_hold",  32'(a_win),     32'd1);

        // Freeze: sample 33, then en=1 with sample_vld=1 for 10 cycles
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_cycle(1'b1, 1'b1, 1'b0, 1'b1);
            seen = seen | a_ld1 | a_ld2 | a_ld3 | a_ld4 | a_out_vld;
        end
        check("t4_no_strobe", 32'(seen),    32'd0);
        check("t4_state",     32'(a_state), 32'd2);
        check("t4_win",       32'(a_win),   32'd1);
        // Sample 34 completes the held segment
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_resume_ld1", 32'(a_ld1), 32'd1);
        check("t4_resume_ld2", 32'(a_ld2), 32'd0);

        // restart coincident with sample 48 (which would strobe ld_s4)
        a_samples(13);
        a_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("t5_no_ld4", 32'(a_ld4),   32'd0);
        check("t5_no_ld1", 32'(a_ld1),   32'd0);
        check("t5_state",  32'(a_state), 32'd0);
        check("t5_full",   32'(a_full),  32'd0);
        check("t5_win",    32'(a_win),   32'd0);
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_refill", 32'(a_state), 32'd1);
        check("t5_c0_clr", 32'(a_ld1),   32'd0);
        a_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_ld1_fresh", 32'(a_ld1), 32'd1);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Default parameters: mid-window reset after 3025 samples
        b_cycle(1'b0, 1'b0);
        b_cycle(1'b0, 1'b0);
        check("b_rst_state", 32'(b_state), 32'd0);
        n1 = 0;
        for (int i = 1; i <= 3025; i++) begin
            b_cycle(1'b1, 1'b1);
            if (b_ld1) n1++;
        end
        check("b_pre_ld1_cnt", 32'(n1),      32'd60);
        check("b_pre_full",    32'(b_full),  32'h3);
        check("b_pre_state",   32'(b_state), 32'd1);
        b_cycle(1'b0, 1'b0);
        check("b_mid_rst_full",  32'(b_full),  32'd0);
        check("b_mid_rst_state", 32'(b_state), 32'd0);

        // 60000 samples from a clean start: one 240 s window
        n1 = 0; n4 = 0; nov = 0; first1 = 0; first4 = 0; ov_at = 0;
        for (int i = 1; i <= 60000; i++) begin
            b_cycle(1'b1, 1'b1);
            if (b_ld1) begin
                n1++;
                if (first1 == 0) first1 = i;
            end
            if (b_ld4) begin
                n4++;
                if (first4 == 0) first4 = i;
            end
            if (b_out_vld) begin
                nov++;
                ov_at = i;
            end
        end
        b_cycle(1'b0, 1'b1);
        if (b_out_vld) begin
            nov++;
            ov_at = 60001;
        end
        check("b_first_ld1", 32'(first1), 32'd50);
        check("b_ld1_cnt",   32'(n1),     32'd1200);
        check("b_first_ld4", 32'(first4), 32'd7500);
        check("b_ld4_cnt",   32'(n4),     32'd8);
        check("b_ovld_cnt",  32'(nov),    32'd1);
        check("b_ovld_at",   32'(ov_at),  32'd60001);
        check("b_win",       32'(b_win),  32'd1);
        check("b_state",     32'(b_state),32'd2);
        check("b_full",      32'(b_full), 32'hf);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
